// File: rtl/iex_imem_elastic.sv
// iex_imem_elastic
// Elastic EX->MEM pipeline register with a one-entry skid buffer.
//
// The main entry drives every *m output directly; the skid entry catches the
// one instruction EX may still push in the cycle MEM stalls.  in_ready is
// taken straight from a state register bit, so there is no combinational
// path from out_ready (or any input) to any output.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   flush              synchronous squash of both entries (highest priority)
//   in_valid/in_ready  EX-side handshake (in_ready registered)
//   aluresulte, writedatae, rde, pcplus4e, ctrle   EX payload
//   out_valid/out_ready MEM-side handshake
//   aluresultm, writedatm, rdm, pcplus4m, ctrlm    held payload (0 when invalid)
//   occupancy          number of held entries, 0..2
//
// state | meaning
// ------+----------------------------------------------
// EMPTY | no entry held, main and skid invalid
// ONE   | main valid, skid invalid
// FULL  | main and skid valid, skid younger than main
//
// Encoding: bit0 = main valid, bit1 = skid valid.

module iex_imem_elastic #(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int CTRLW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  aluresulte,
    input  logic [XLEN-1:0]  writedatae,
    input  logic [REGW-1:0]  rde,
    input  logic [XLEN-1:0]  pcplus4e,
    input  logic [CTRLW-1:0] ctrle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  aluresultm,
    output logic [XLEN-1:0]  writedatm,
    output logic [REGW-1:0]  rdm,
    output logic [XLEN-1:0]  pcplus4m,
    output logic [CTRLW-1:0] ctrlm,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic accept;
    logic drain;

    // Datapath steering produced by the next-state logic
    logic main_ld_in;
    logic main_ld_skid;
    logic main_clr;
    logic skid_ld;
    logic skid_clr;

    logic [XLEN-1:0]  main_alu,  skid_alu;
    logic [XLEN-1:0]  main_wd,   skid_wd;
    logic [REGW-1:0]  main_rd,   skid_rd;
    logic [XLEN-1:0]  main_pc,   skid_pc;
    logic [CTRLW-1:0] main_ctrl, skid_ctrl;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath steering
    always_comb begin
        state_d      = state_q;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        main_clr     = 1'b0;
        skid_ld      = 1'b0;
        skid_clr     = 1'b0;

        if (flush) begin
            // A drain in this cycle has already been seen by MEM; any accept
            // is simply dropped along with everything held.
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_ld_in = 1'b1;
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_ld_in = 1'b1;
                    end else if (drain) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end else if (accept) begin
                        skid_ld = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_ld_skid = 1'b1;
                        skid_clr     = 1'b1;
                        state_d      = ONE;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // Outputs decode single register bits only
    always_comb begin
        out_valid = state_q[0];
        in_ready  = ~state_q[1];
        occupancy = {1'b0, state_q[0]} + {1'b0, state_q[1]};
    end

    // Main entry: cleared whenever it goes invalid so no stale control
    // bits are ever presented to MEM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_alu  <= '0;
            main_wd   <= '0;
            main_rd   <= '0;
            main_pc   <= '0;
            main_ctrl <= '0;
        end else if (main_clr) begin
            main_alu  <= '0;
            main_wd   <= '0;
            main_rd   <= '0;
            main_pc   <= '0;
            main_ctrl <= '0;
        end else if (main_ld_in) begin
            main_alu  <= aluresulte;
            main_wd   <= writedatae;
            main_rd   <= rde;
            main_pc   <= pcplus4e;
            main_ctrl <= ctrle;
        end else if (main_ld_skid) begin
            main_alu  <= skid_alu;
            main_wd   <= skid_wd;
            main_rd   <= skid_rd;
            main_pc   <= skid_pc;
            main_ctrl <= skid_ctrl;
        end
    end

    // Skid entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_alu  <= '0;
            skid_wd   <= '0;
            skid_rd   <= '0;
            skid_pc   <= '0;
            skid_ctrl <= '0;
        end else if (skid_clr) begin
            skid_alu  <= '0;
            skid_wd   <= '0;
            skid_rd   <= '0;
            skid_pc   <= '0;
            skid_ctrl <= '0;
        end else if (skid_ld) begin
            skid_alu  <= aluresulte;
            skid_wd   <= writedatae;
            skid_rd   <= rde;
            skid_pc   <= pcplus4e;
            skid_ctrl <= ctrle;
        end
    end

    assign aluresultm = main_alu;
    assign writedatm  = main_wd;
    assign rdm        = main_rd;
    assign pcplus4m   = main_pc;
    assign ctrlm      = main_ctrl;

endmodule

// File: tb/tb_iex_imem_elastic.sv
// Scoreboard bench for iex_imem_elastic, built at XLEN=64, REGW=6, CTRLW=8.
// Inputs change 1 time unit after each rising edge; the monitor samples on the
// falling edge, predicts the coming edge and compares popped entries on drain.

module tb_iex_imem_elastic;

    localparam int XLEN  = 64;
    localparam int REGW  = 6;
    localparam int CTRLW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  aluresulte;
    logic [XLEN-1:0]  writedatae;
    logic [REGW-1:0]  rde;
    logic [XLEN-1:0]  pcplus4e;
    logic [CTRLW-1:0] ctrle;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  aluresultm;
    logic [XLEN-1:0]  writedatm;
    logic [REGW-1:0]  rdm;
    logic [XLEN-1:0]  pcplus4m;
    logic [CTRLW-1:0] ctrlm;
    logic [1:0]       occupancy;

    iex_imem_elastic #(.XLEN(XLEN), .REGW(REGW), .CTRLW(CTRLW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluresulte(aluresulte), .writedatae(writedatae), .rde(rde),
        .pcplus4e(pcplus4e), .ctrle(ctrle),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluresultm(aluresultm), .writedatm(writedatm), .rdm(rdm),
        .pcplus4m(pcplus4m), .ctrlm(ctrlm), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0]  alu;
        logic [XLEN-1:0]  wd;
        logic [REGW-1:0]  rd;
        logic [XLEN-1:0]  pc;
        logic [CTRLW-1:0] ctrl;
    } ent_t;

    ent_t exp_q[$];
    int   m_occ  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic acc, drn;
        ent_t e;
        if (reset) begin
            exp_q.delete();
            m_occ = 0;
        end
        chk("in_ready",  {63'd0, in_ready},  {63'd0, (m_occ < 2)});
        chk("out_valid", {63'd0, out_valid}, {63'd0, (m_occ > 0)});
        chk("occupancy", {62'd0, occupancy}, 64'(m_occ));
        if (!out_valid) begin
            chk("idle_ctrlm", {56'd0, ctrlm}, 64'd0);
            chk("idle_rdm",   {58'd0, rdm},   64'd0);
            chk("idle_alu",   aluresultm,     64'd0);
            chk("idle_wd",    writedatm,      64'd0);
            chk("idle_pc",    pcplus4m,       64'd0);
        end
        if (!reset) begin
            acc = in_valid && (m_occ < 2);
            drn = out_ready && (m_occ > 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("drain_without_entry", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("alu",  aluresultm,        e.alu);
                    chk("wd",   writedatm,         e.wd);
                    chk("rd",   {58'd0, rdm},      {58'd0, e.rd});
                    chk("pc",   pcplus4m,          e.pc);
                    chk("ctrl", {56'd0, ctrlm},    {56'd0, e.ctrl});
                end
            end
            if (flush) begin
                exp_q.delete();
                m_occ = 0;
            end else begin
                if (acc) exp_q.push_back({aluresulte, writedatae, rde, pcplus4e, ctrle});
                m_occ = m_occ + int'(acc) - int'(drn);
            end
        end
    end

    // One cycle of stimulus, entered and left at posedge+1
    task automatic cyc(input logic v, input logic [XLEN-1:0] alu, input logic [REGW-1:0] rd,
                       input logic [CTRLW-1:0] ctrl, input logic ordy, input logic fl);
        in_valid   = v;
        aluresulte = alu;
        writedatae = alu ^ 64'hFFFF;
        rde        = rd;
        pcplus4e   = alu + 64'd4;
        ctrle      = ctrl;
        out_ready  = ordy;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        aluresulte = '0; writedatae = '0; rde = '0; pcplus4e = '0; ctrle = '0;
        #2;
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Streaming, back to back
        cyc(1, 64'h10, 6'd1, 8'h01, 1, 0);
        cyc(1, 64'h20, 6'd2, 8'h02, 1, 0);
        cyc(1, 64'h30, 6'd3, 8'h03, 1, 0);
        chk("stream_occ", {62'd0, occupancy}, 64'd1);
        cyc(0, 64'h0, 6'd0, 8'h00, 1, 0);
        cyc(0, 64'h0, 6'd0, 8'h00, 1, 0);

        // Stall into skid; an offer while FULL must be refused
        cyc(1, 64'h100, 6'd4, 8'h11, 0, 0);
        cyc(1, 64'h200, 6'd5, 8'h12, 0, 0);
        chk("stall_occ",      {62'd0, occupancy}, 64'd2);
        chk("stall_in_ready", {63'd0, in_ready},  64'd0);
        chk("stall_alu",      aluresultm,         64'h100);
        cyc(1, 64'h999, 6'd6, 8'h13, 0, 0);
        chk("full_hold_alu",  aluresultm,         64'h100);
        cyc(0, 64'h0, 6'd0, 8'h00, 1, 0);
        chk("skid_to_main",   aluresultm,         64'h200);
        chk("ready_back",     {63'd0, in_ready},  64'd1);
        cyc(0, 64'h0, 6'd0, 8'h00, 1, 0);

        // Flush in FULL with a same-cycle offer
        cyc(1, 64'h300, 6'd7, 8'hFF, 0, 0);
        cyc(1, 64'h400, 6'd8, 8'hFF, 0, 0);
        cyc(1, 64'h500, 6'd9, 8'hFF, 0, 1);
        chk("flush_full_occ",  {62'd0, occupancy}, 64'd0);
        chk("flush_full_ctrl", {56'd0, ctrlm},     64'd0);
        cyc(0, 64'h0, 6'd0, 8'h00, 1, 0);

        // Flush with a same-cycle drain from ONE
        cyc(1, 64'h600, 6'd10, 8'h21, 0, 0);
        cyc(1, 64'h700, 6'd11, 8'h22, 1, 1);
        chk("flush_drain_occ", {62'd0, occupancy}, 64'd0);
        cyc(0, 64'h0, 6'd0, 8'h00, 1, 0);

        // Full-width payload
        cyc(1, 64'hDEAD_BEEF_0000_0001, 6'd63, 8'hA5, 0, 0);
        chk("wide_alu", aluresultm,      64'hDEAD_BEEF_0000_0001);
        chk("wide_rd",  {58'd0, rdm},    64'd63);
        chk("wide_pc",  pcplus4m,        64'hDEAD_BEEF_0000_0005);
        cyc(0, 64'h0, 6'd0, 8'h00, 1, 0);
        chk("wide_cleared", aluresultm,  64'd0);

        // Asynchronous reset mid-stream
        cyc(1, 64'h800, 6'd12, 8'h31, 0, 0);
        cyc(1, 64'h900, 6'd13, 8'h32, 0, 0);
        in_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("arst_occ",       {62'd0, occupancy}, 64'd0);
        chk("arst_alu",       aluresultm,         64'd0);
        chk("arst_ctrl",      {56'd0, ctrlm},     64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1, 64'hA00, 6'd14, 8'h41, 1, 0);
        cyc(0, 64'h0, 6'd0, 8'h00, 1, 0);
        cyc(0, 64'h0, 6'd0, 8'h00, 1, 0);

        chk("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/iex_imem_elastic.md
# iex_imem_elastic

Parametrised, elastic EX→MEM pipeline register for the pipelined RISC-V core. It carries the ALU result, store data, destination register, PC+4 and a control vector from execute to memory. A valid/ready handshake on both sides and a one-entry skid buffer let MEM stall without a combinational ready path back into EX. A synchronous flush squashes in-flight entries on redirects.

## Interface
- XLEN, 32, datapath width of aluresult, writedata, pcplus4
- REGW, 5, destination register index width
- CTRLW, 4, width of control vector passed to MEM/WB (e.g. regwrite, memwrite, resultsrc[1:0])
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept this cycle (registered)
- aluresulte  in  XLEN  ALU result from EX
- writedatae  in  XLEN  store data from EX
- rde  in  REGW  destination register from EX
- pcplus4e  in  XLEN  PC+4 from EX
- ctrle  in  CTRLW  control vector from EX
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes entry this cycle
- aluresultm  out  XLEN  held ALU result
- writedatm  out  XLEN  held store data
- rdm  out  REGW  held destination register
- pcplus4m  out  XLEN  held PC+4
- ctrlm  out  CTRLW  held control vector
- occupancy  out  2  entries held: 0, 1 or 2

## Operation
- Storage: main entry (drives all *m outputs directly) and skid entry; each is {valid, aluresult, writedata, rd, pcplus4, ctrl}.
- Accept = in_valid && in_ready; drain = out_valid && out_ready.
- in_ready = !skid.valid; out_valid = main.valid; occupancy = main.valid + skid.valid.
- States: EMPTY (main invalid), ONE (main valid, skid invalid), FULL (both valid).
- EMPTY: accept → main ← inputs, ONE; else hold.
- ONE: accept and drain → main ← inputs, stay ONE; drain only → EMPTY; accept only → skid ← inputs, FULL; neither → hold.
- FULL: drain → main ← skid, skid cleared, ONE; else hold. No accept possible (in_ready=0).
- Invalidated entries have all data fields zeroed, so ctrlm/rdm are 0 whenever out_valid=0. No stale regwrite/memwrite reaches MEM.
- flush: next state EMPTY, both entries zeroed. A same-cycle accept is discarded. A same-cycle drain counts as completed downstream. flush has priority over every other event.
- Inputs are ignored when in_valid=0. Data is captured only on accept.

## Timing
- Reset (async): all outputs 0 except in_ready=1. out_valid=0, occupancy=0, state EMPTY.
- First rising edge after reset deassertion may accept.
- Latency: accept at edge N → out_valid=1 and data on *m outputs after edge N.
- Throughput: 1 entry/cycle sustained with out_ready held high.
- in_ready is a register output. It falls the cycle after a stall fills skid and rises the cycle after FULL drains.
- No combinational path from out_ready to in_ready or from inputs to outputs.
- Ordering is strictly FIFO: skid data is always younger than main.
- Reset asserted mid-operation clears both entries immediately, regardless of clk.

## Test plan
- Reset: assert reset with in_valid=1 mid-stream → all *m outputs 0, out_valid=0, in_ready=1, occupancy=0 with no clock edge needed.
- Streaming: out_ready=1; push aluresult 0x10, 0x20, 0x30 on consecutive cycles → identical values appear on aluresultm one cycle later, back to back. occupancy stays 1.
- Stall/skid: push A=0x100, then out_ready=0 while pushing B=0x200 → occupancy=2, in_ready=0, aluresultm=0x100. Raise out_ready → 0x100 then 0x200 on consecutive cycles, in_ready returns to 1.
- Flush: in FULL with ctrle=4'hF entries, assert flush with in_valid=1 → next cycle out_valid=0, ctrlm=0, rdm=0, occupancy=0. The new input is not captured.
- Flush + drain: ONE state, out_ready=1, flush=1, in_valid=1 → entry counted consumed, stage EMPTY, no capture.
- Width parameters: XLEN=64, REGW=6, CTRLW=8; push 64'hDEAD_BEEF_0000_0001, rd=6'd63 → values pass through unaltered. Upper bits zero after drain.
